// File: rtl/onehot_rr_arbiter.sv
// Round-robin front end for the registered one-hot operand mux: picks a requester,
// drives the mux select, and tracks the mux's one-cycle latency for the output handshake.
//
// Handshake rules: a transfer happens on an edge where valid and ready are both high.
// A requester holds req_valid (and its mux data) until it sees req_ready.
// req_ready[grant_idx] follows out_ready while the mux output is valid, so each upstream
// transfer coincides with the downstream one.
module onehot_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] en,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [NUM_REQ-1:0]   en_n;
  logic [IDX_W-1:0]     grant_n, ptr, ptr_n, ptr_after;
  logic                 out_valid_n;
  logic [NUM_REQ-1:0]   masked_req;
  logic [IDX_W-1:0]     pick_idle, pick_valid;

  // First set bit of m, scanning from p upward and wrapping.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] m,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] r;
    int               t;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      t = int'(p) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      if (m[t]) r = IDX_W'(t);
    end
    return r;
  endfunction

  assign ptr_after  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(grant_idx + 1'b1);
  assign masked_req = req_valid & ~en;
  assign pick_idle  = rr_pick(req_valid, ptr);
  assign pick_valid = rr_pick(masked_req, ptr_after);
  assign state_dbg  = state;

  always_comb begin
    state_n     = state;
    en_n        = en;
    grant_n     = grant_idx;
    out_valid_n = out_valid;
    ptr_n       = ptr;
    req_ready   = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          en_n    = ONE << pick_idle;
          grant_n = pick_idle;
          state_n = FILL;
        end
      end
      FILL: begin
        out_valid_n = 1'b1;
        state_n     = VALID;
      end
      VALID: begin
        // en is the one-hot of grant_idx, so it doubles as the ready mask.
        req_ready = (out_ready && rst_n) ? en : '0;
        if (out_ready) begin
          ptr_n       = ptr_after;
          out_valid_n = 1'b0;
          if (|masked_req) begin
            en_n    = ONE << pick_valid;
            grant_n = pick_valid;
            state_n = FILL;
          end else begin
            en_n    = '0;
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        en_n        = '0;
        grant_n     = '0;
        out_valid_n = 1'b0;
        state_n     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      en        <= '0;
      grant_idx <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      state     <= state_n;
      en        <= en_n;
      grant_idx <= grant_n;
      out_valid <= out_valid_n;
      ptr       <= ptr_n;
    end
  end

  // A granted requester must keep its valid up until it is accepted.
  a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE) |-> |(req_valid & en));
  a_en_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(en) && ((en == '0) == (state == IDLE)));
  a_valid_state: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> (state == VALID));

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed grant orders and timings.
module tb_onehot_rr_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, en, hold_mask = '0;
  logic [1:0]   grant_idx, state_dbg;
  logic         out_valid, out_ready = 1'b0;

  logic [3:0]   rv4 = '0, rr4, en4;
  logic [1:0]   gi4, sd4;
  logic         ov4, ordy4 = 1'b0;

  onehot_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .en(en), .grant_idx(grant_idx), .out_valid(out_valid), .out_ready(out_ready),
    .state_dbg(state_dbg)
  );

  onehot_rr_arbiter #(.NUM_REQ(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_ready(rr4),
    .en(en4), .grant_idx(gi4), .out_valid(ov4), .out_ready(ordy4),
    .state_dbg(sd4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int xfer_q[$];
  int xfer_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: who holds the grant, how long it has held it, where priority starts.
  bit m_busy = 1'b0;
  int m_gnt = 0;
  int m_age = 0;
  int m_ptr = 0;

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] m;
    if (!rst_n) begin
      m_busy = 1'b0; m_gnt = 0; m_age = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (|req_valid) begin
        m_gnt = pick(req_valid, m_ptr); m_busy = 1'b1; m_age = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (out_ready) begin
      m_ptr = (m_gnt + 1) % N;
      m = req_valid;
      m[m_gnt] = 1'b0;
      if (|m) begin
        m_gnt = pick(m, m_ptr); m_age = 0;
      end else begin
        m_busy = 1'b0; m_gnt = 0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_en, exp_rr;
    if (chk_on) begin
      exp_en = m_busy ? N'(1 << m_gnt) : '0;
      exp_rr = (rst_n && m_busy && m_age >= 1 && out_ready) ? exp_en : '0;
      chk("model_en", 32'(en), 32'(exp_en));
      chk("model_grant_idx", 32'(grant_idx), m_busy ? m_gnt : 0);
      chk("model_out_valid", 32'(out_valid), 32'(m_busy && m_age >= 1));
      chk("model_req_ready", 32'(req_ready), 32'(exp_rr));
    end
  end

  // One clock: log transfers seen before the edge, then requesters that were
  // accepted drop valid unless they keep requesting.
  task automatic cycle();
    logic [N-1:0] x;
    @(negedge clk);
    x = req_valid & req_ready;
    for (int i = 0; i < N; i++)
      if (x[i]) begin
        xfer_q.push_back(i);
        xfer_cyc.push_back(cyc);
      end
    @(posedge clk);
    #1;
    req_valid = (req_valid & ~x) | (x & hold_mask);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; hold_mask = '0; out_ready = 1'b0; rv4 = '0; ordy4 = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    xfer_q.delete();
    xfer_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk_on = 1'b1;
    chk("reset_en", 32'(en), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_grant_idx", 32'(grant_idx), 0);
    chk("reset_state_idle", 32'(state_dbg), 0);

    // Single request from requester 1.
    req_valid = 3'b010; out_ready = 1'b1;
    cycle();
    chk("t1_en_c1", 32'(en), 32'h2);
    chk("t1_ov_c1", 32'(out_valid), 0);
    cycle();
    chk("t1_ov_c2", 32'(out_valid), 1);
    chk("t1_rr_c2", 32'(req_ready), 32'h2);
    cycle();
    chk("t1_en_c3", 32'(en), 0);
    chk("t1_idle_c3", 32'(state_dbg), 0);

    // All three requesting continuously.
    do_reset();
    hold_mask = 3'b111; req_valid = 3'b111; out_ready = 1'b1;
    repeat (14) cycle();
    chk("t2_xfer_count_ge6", 32'(xfer_q.size() >= 6), 1);
    if (xfer_q.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("t2_grant_order", xfer_q[k], k % 3);
      for (int k = 1; k < 6; k++) chk("t2_spacing", xfer_cyc[k] - xfer_cyc[k-1], 2);
    end
    hold_mask = '0;
    repeat (8) cycle();

    // Stall with requester 2 granted.
    do_reset();
    req_valid = 3'b100; out_ready = 1'b0;
    cycle();
    cycle();
    repeat (5) begin
      cycle();
      chk("t3_stall_en", 32'(en), 32'h4);
      chk("t3_stall_ov", 32'(out_valid), 1);
      chk("t3_stall_rr", 32'(req_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_rr_on_ready", 32'(req_ready), 32'h4);
    repeat (5) cycle();
    chk("t3_one_xfer", xfer_q.size(), 1);
    if (xfer_q.size() >= 1) chk("t3_xfer_idx", xfer_q[0], 2);

    // Requester 0 alone, then requester 1 joins.
    do_reset();
    hold_mask = 3'b001; req_valid = 3'b001; out_ready = 1'b1;
    repeat (9) cycle();
    chk("t4_xfer_count", xfer_q.size(), 3);
    if (xfer_q.size() >= 3) begin
      chk("t4_gap_a", xfer_cyc[1] - xfer_cyc[0], 3);
      chk("t4_gap_b", xfer_cyc[2] - xfer_cyc[1], 3);
    end
    req_valid = req_valid | 3'b010;
    cycle();
    chk("t4_join_en", 32'(en), 32'h2);
    hold_mask = '0;
    repeat (6) cycle();
    chk("t4_xfer_count2", 32'(xfer_q.size() >= 5), 1);
    if (xfer_q.size() >= 5) begin
      chk("t4_join_first", xfer_q[3], 1);
      chk("t4_join_then0", xfer_q[4], 0);
    end

    // Reset in VALID with ptr=1 and requesters 0 and 2 pending.
    do_reset();
    req_valid = 3'b001; out_ready = 1'b1;
    repeat (3) cycle();
    req_valid = 3'b101; out_ready = 1'b0;
    cycle();
    cycle();
    chk("t5_pre_en", 32'(en), 32'h4);
    chk("t5_pre_ov", 32'(out_valid), 1);
    rst_n = 1'b0; out_ready = 1'b1;
    #1;
    chk("t5_rr_in_reset", 32'(req_ready), 0);
    cycle();
    rst_n = 1'b1;
    chk("t5_post_en", 32'(en), 0);
    chk("t5_post_ov", 32'(out_valid), 0);
    chk("t5_no_xfer_in_reset", xfer_q.size(), 1);
    cycle();
    chk("t5_regrant_en", 32'(en), 32'h1);
    chk("t5_regrant_idx", 32'(grant_idx), 0);
    repeat (8) cycle();

    // Four-requester build.
    do_reset();
    rv4 = 4'b1000; ordy4 = 1'b1;
    cycle();
    chk("t6_en4_c1", 32'(en4), 32'h8);
    chk("t6_gi4_c1", 32'(gi4), 3);
    cycle();
    chk("t6_ov4_c2", 32'(ov4), 1);
    chk("t6_rr4_c2", 32'(rr4), 32'h8);
    cycle();
    rv4 = 4'b0001;
    chk("t6_en4_idle", 32'(en4), 0);
    cycle();
    chk("t6_gi4_wrap", 32'(gi4), 0);
    chk("t6_en4_wrap", 32'(en4), 32'h1);
    cycle();
    chk("t6_rr4_c5", 32'(rr4), 32'h1);
    cycle();
    rv4 = '0;
    cycle();
    chk("t6_idle4", 32'(en4), 0);
    chk("final_idle", 32'(state_dbg), 0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
